// File: rtl/mii_frame_gen.sv
// MII (4-bit, 100Base-TX) transmit frame generator.
// Emits preamble/SFD, a selectable pattern payload, optional zero padding,
// the CRC-32 FCS and an inter-frame gap. Frame parameters are captured on start.
module mii_frame_gen #(
  parameter int LEN_W       = 11,
  parameter int PAYLOAD_MAX = 1500,
  parameter int MIN_PAYLOAD = 46,
  parameter int IFG_BYTES   = 12,
  parameter int CNT_W       = 16
) (
  input  logic             clk_25Mz,
  input  logic             reset_n,
  input  logic             start,
  input  logic [LEN_W-1:0] frame_len,
  input  logic [1:0]       pattern_sel,
  input  logic [7:0]       seed,
  output logic             TX_EN,
  output logic [3:0]       TXD,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [31:0]      crc_out
);

  // Largest byte count any state has to walk through (at least 8 for the preamble).
  localparam int MAXB0 = (PAYLOAD_MAX > MIN_PAYLOAD) ? PAYLOAD_MAX : MIN_PAYLOAD;
  localparam int MAXB1 = (MAXB0 > IFG_BYTES) ? MAXB0 : IFG_BYTES;
  localparam int MAXB  = (MAXB1 > 8) ? MAXB1 : 8;
  localparam int CW    = $clog2(2 * MAXB + 1);

  localparam logic [31:0] PMAX     = 32'(PAYLOAD_MAX);
  localparam logic [31:0] PMIN     = 32'(MIN_PAYLOAD);
  localparam logic [31:0] POLY     = 32'hEDB8_8320;
  localparam logic [CW-1:0] PRE_LAST = CW'(15);
  localparam logic [CW-1:0] FCS_LAST = CW'(7);
  localparam logic [CW-1:0] IFG_LAST = CW'(2 * IFG_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_PAY,
    S_PAD,
    S_FCS,
    S_IFG
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    pay_nib_q, pay_nib_d;
  logic [CW-1:0]    pad_nib_q, pad_nib_d;
  logic [1:0]       sel_q, sel_d;
  logic [7:0]       byte_q, byte_d;
  logic [31:0]      crc_q, crc_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [31:0]      crc_out_q, crc_out_d;

  logic [31:0]      eff_len;
  logic [31:0]      pad_len;
  logic [31:0]      fcs;
  logic [7:0]       init_byte;

  // One byte through the reflected CRC-32 register, LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int unsigned i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = {1'b0, r[31:1]} ^ POLY;
      else             r = {1'b0, r[31:1]};
    end
    return r;
  endfunction

  // Successor of the current payload byte for the latched pattern mode.
  function automatic logic [7:0] next_byte(input logic [1:0] sel, input logic [7:0] b);
    logic [7:0] r;
    case (sel)
      2'd0:    r = b + 8'd1;
      2'd1:    r = b;
      2'd2:    r = {b[6:0], 1'b0} ^ (b[7] ? 8'h1D : 8'h00);
      default: r = ~b;
    endcase
    return r;
  endfunction

  // Clamp the requested length and derive the padding needed to reach the minimum.
  always_comb begin
    eff_len = '0;
    pad_len = '0;
    eff_len = (32'(frame_len) > PMAX) ? PMAX : 32'(frame_len);
    pad_len = (eff_len < PMIN) ? (PMIN - eff_len) : '0;
    case (pattern_sel)
      2'd2:    init_byte = (seed == 8'h00) ? 8'h01 : seed;
      2'd3:    init_byte = 8'h55;
      default: init_byte = seed;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_25Mz or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      pay_nib_q   <= '0;
      pad_nib_q   <= '0;
      sel_q       <= '0;
      byte_q      <= '0;
      crc_q       <= '1;
      frame_cnt_q <= '0;
      crc_out_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pay_nib_q   <= pay_nib_d;
      pad_nib_q   <= pad_nib_d;
      sel_q       <= sel_d;
      byte_q      <= byte_d;
      crc_q       <= crc_d;
      frame_cnt_q <= frame_cnt_d;
      crc_out_q   <= crc_out_d;
    end
  end

  // Next-state and nibble output; TX_EN/TXD decode straight from state so a reset drops them at once.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CW'(1);
    pay_nib_d   = pay_nib_q;
    pad_nib_d   = pad_nib_q;
    sel_d       = sel_q;
    byte_d      = byte_q;
    crc_d       = crc_q;
    frame_cnt_d = frame_cnt_q;
    crc_out_d   = crc_out_q;
    TX_EN       = 1'b0;
    TXD         = 4'h0;
    done        = 1'b0;
    fcs         = ~crc_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start) begin
          pay_nib_d = CW'(2 * eff_len);
          pad_nib_d = CW'(2 * pad_len);
          sel_d     = pattern_sel;
          byte_d    = init_byte;
          crc_d     = '1;
          state_d   = S_PRE;
        end
      end
      S_PRE: begin
        TX_EN = 1'b1;
        TXD   = (cnt_q == PRE_LAST) ? 4'hD : 4'h5;
        if (cnt_q == PRE_LAST) begin
          cnt_d = '0;
          if (pay_nib_q != '0)      state_d = S_PAY;
          else if (pad_nib_q != '0) state_d = S_PAD;
          else                      state_d = S_FCS;
        end
      end
      S_PAY: begin
        TX_EN = 1'b1;
        TXD   = cnt_q[0] ? byte_q[7:4] : byte_q[3:0];
        if (cnt_q[0]) begin
          crc_d  = crc_byte(crc_q, byte_q);
          byte_d = next_byte(sel_q, byte_q);
        end
        if (cnt_q == pay_nib_q - CW'(1)) begin
          cnt_d   = '0;
          state_d = (pad_nib_q != '0) ? S_PAD : S_FCS;
        end
      end
      S_PAD: begin
        TX_EN = 1'b1;
        if (cnt_q[0]) crc_d = crc_byte(crc_q, 8'h00);
        if (cnt_q == pad_nib_q - CW'(1)) begin
          cnt_d   = '0;
          state_d = S_FCS;
        end
      end
      S_FCS: begin
        TX_EN = 1'b1;
        TXD   = fcs[{cnt_q[2:0], 2'b00} +: 4];
        if (cnt_q == FCS_LAST) begin
          cnt_d   = '0;
          state_d = S_IFG;
        end
      end
      S_IFG: begin
        if (cnt_q == IFG_LAST) begin
          done        = 1'b1;
          frame_cnt_d = frame_cnt_q + CNT_W'(1);
          crc_out_d   = ~crc_q;
          cnt_d       = '0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy      = (state_q != S_IDLE);
  assign frame_cnt = frame_cnt_q;
  assign crc_out   = crc_out_q;

endmodule

// File: tb/tb_mii_frame_gen.sv
// Directed bench for mii_frame_gen: one default instance (A) and one with
// padding disabled and a 2-bit frame counter (B).
module tb_mii_frame_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stA, stB;
  logic [10:0] lenA, lenB;
  logic [1:0]  selA, selB;
  logic [7:0]  seedA, seedB;

  logic        txenA, txenB, busyA, busyB, doneA, doneB;
  logic [3:0]  txdA, txdB;
  logic [15:0] fcA;
  logic [1:0]  fcB;
  logic [31:0] crcA, crcB;

  always #20 clk = ~clk;

  mii_frame_gen u_a (
    .clk_25Mz(clk), .reset_n(rst_n), .start(stA), .frame_len(lenA),
    .pattern_sel(selA), .seed(seedA), .TX_EN(txenA), .TXD(txdA),
    .busy(busyA), .done(doneA), .frame_cnt(fcA), .crc_out(crcA)
  );

  mii_frame_gen #(.MIN_PAYLOAD(0), .CNT_W(2)) u_b (
    .clk_25Mz(clk), .reset_n(rst_n), .start(stB), .frame_len(lenB),
    .pattern_sel(selB), .seed(seedB), .TX_EN(txenB), .TXD(txdB),
    .busy(busyB), .done(doneB), .frame_cnt(fcB), .crc_out(crcB)
  );

  int pass_cnt = 0;
  int total_cnt = 0;
  int fail_cnt = 0;

  logic [3:0] nibs[$];
  logic [7:0] exp_b[$];
  int         en_len;
  int         ifg_len;
  logic       ifg_bad;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic en(input int inst);
    return (inst != 0) ? txenB : txenA;
  endfunction
  function automatic logic [3:0] txd(input int inst);
    return (inst != 0) ? txdB : txdA;
  endfunction
  function automatic logic dn(input int inst);
    return (inst != 0) ? doneB : doneA;
  endfunction

  function automatic logic [31:0] crc32(input logic [7:0] b[$]);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (b[i]) begin
      c = c ^ {24'h0, b[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic logic [63:0] pre_word();
    logic [63:0] w;
    w = '0;
    for (int i = 0; i < 16; i++) if (i < nibs.size()) w = w | (64'(nibs[i]) << (4 * i));
    return w;
  endfunction

  function automatic logic [31:0] fcs_word();
    logic [31:0] w;
    w = '0;
    if (en_len >= 8 && nibs.size() >= 8)
      for (int k = 0; k < 8; k++) w = w | (32'(nibs[en_len - 8 + k]) << (4 * k));
    return w;
  endfunction

  function automatic int byte_errs(input int n);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      if (17 + 2 * i >= nibs.size() || i >= exp_b.size()) bad++;
      else if ({nibs[17 + 2 * i], nibs[16 + 2 * i]} !== exp_b[i]) bad++;
    end
    return bad;
  endfunction

  // Start one frame, capture every nibble while TX_EN is high, then time the gap to done.
  task automatic run_frame(input int inst, input logic [10:0] len, input logic [1:0] sel,
                           input logic [7:0] sd);
    @(negedge clk);
    if (inst == 0) begin stA = 1'b1; lenA = len; selA = sel; seedA = sd; end
    else           begin stB = 1'b1; lenB = len; selB = sel; seedB = sd; end
    @(negedge clk);
    stA = 1'b0;
    stB = 1'b0;
    nibs.delete();
    en_len = 0;
    while (en(inst) && en_len < 4000) begin
      nibs.push_back(txd(inst));
      en_len++;
      @(negedge clk);
    end
    ifg_len = 1;
    ifg_bad = 1'b0;
    while (!dn(inst) && ifg_len < 100) begin
      if (txd(inst) !== 4'h0 || en(inst)) ifg_bad = 1'b1;
      @(negedge clk);
      ifg_len++;
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    stA = 1'b0; stB = 1'b0;
    lenA = '0; lenB = '0; selA = '0; selB = '0; seedA = '0; seedB = '0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_txen", 64'(txenA), 64'd0);
    chk("rst_txd", 64'(txdA), 64'd0);
    chk("rst_busy", 64'(busyA), 64'd0);
    chk("rst_done", 64'(doneA), 64'd0);
    chk("rst_cnt", 64'(fcA), 64'd0);
    chk("rst_crc", 64'(crcA), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // "123456789" check value, no padding
    run_frame(1, 11'd9, 2'd0, 8'h31);
    chk("crc9_enlen", 64'(en_len), 64'd42);
    chk("crc9_pre", pre_word(), 64'hD555_5555_5555_5555);
    exp_b.delete();
    for (int i = 0; i < 9; i++) exp_b.push_back(8'(8'h31 + i));
    chk("crc9_bytes", 64'(byte_errs(9)), 64'd0);
    chk("crc9_fcs", 64'(fcs_word()), 64'hCBF4_3926);
    chk("crc9_ifg", 64'(ifg_len), 64'd24);
    chk("crc9_ifg_quiet", 64'(ifg_bad), 64'd0);
    chk("crc9_crcout", 64'(crcB), 64'hCBF4_3926);
    chk("crc9_cnt", 64'(fcB), 64'd1);
    chk("crc9_busy", 64'(busyB), 64'd0);

    // PRBS-8, seed 0x01 and seed 0x00 give the same bytes
    exp_b = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1D, 8'h3A};
    run_frame(1, 11'd10, 2'd2, 8'h01);
    chk("prbs1_enlen", 64'(en_len), 64'd44);
    chk("prbs1_bytes", 64'(byte_errs(10)), 64'd0);
    chk("prbs1_fcs", 64'(fcs_word()), 64'(crc32(exp_b)));
    run_frame(1, 11'd10, 2'd2, 8'h00);
    chk("prbs0_bytes", 64'(byte_errs(10)), 64'd0);
    chk("prbs0_crcout", 64'(crcB), 64'(crc32(exp_b)));

    // Zero-length payload, no padding
    run_frame(1, 11'd0, 2'd0, 8'h00);
    chk("len0_enlen", 64'(en_len), 64'd24);
    chk("len0_pre", pre_word(), 64'hD555_5555_5555_5555);
    chk("len0_fcs", 64'(fcs_word()), 64'd0);
    chk("len0_crcout", 64'(crcB), 64'd0);

    // Default padding: 10 constant bytes then 36 zeros
    run_frame(0, 11'd10, 2'd1, 8'hA7);
    exp_b.delete();
    for (int i = 0; i < 46; i++) exp_b.push_back((i < 10) ? 8'hA7 : 8'h00);
    chk("pad_enlen", 64'(en_len), 64'd116);
    chk("pad_bytes", 64'(byte_errs(46)), 64'd0);
    chk("pad_fcs", 64'(fcs_word()), 64'(crc32(exp_b)));
    chk("pad_crcout", 64'(crcA), 64'(crc32(exp_b)));
    chk("pad_cnt", 64'(fcA), 64'd1);

    // Oversized request clamps to 1500 alternating bytes
    run_frame(0, 11'd2000, 2'd3, 8'h12);
    exp_b.delete();
    for (int i = 0; i < 1500; i++) exp_b.push_back(i[0] ? 8'hAA : 8'h55);
    chk("clamp_enlen", 64'(en_len), 64'd3024);
    chk("clamp_bytes", 64'(byte_errs(1500)), 64'd0);
    chk("clamp_fcs", 64'(fcs_word()), 64'(crc32(exp_b)));
    chk("clamp_cnt", 64'(fcA), 64'd2);

    // Reset in the middle of payload byte 10
    @(negedge clk);
    stA = 1'b1; lenA = 11'd20; selA = 2'd0; seedA = 8'h00;
    @(negedge clk);
    stA = 1'b0;
    repeat (36) @(negedge clk);
    chk("mid_pre_txen", 64'(txenA), 64'd1);
    chk("mid_pre_txd", 64'(txdA), 64'hA);
    rst_n = 1'b0;
    #1;
    chk("mid_txen", 64'(txenA), 64'd0);
    chk("mid_txd", 64'(txdA), 64'd0);
    chk("mid_busy", 64'(busyA), 64'd0);
    chk("mid_cnt", 64'(fcA), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(0, 11'd10, 2'd0, 8'h00);
    chk("post_rst_enlen", 64'(en_len), 64'd116);
    chk("post_rst_cnt", 64'(fcA), 64'd1);

    // start held high: back-to-back frames, 2-bit counter wraps
    @(negedge clk);
    stB = 1'b1; lenB = 11'd0; selB = 2'd0; seedB = 8'h00;
    for (int f = 0; f < 4; f++) begin
      int n;
      int g;
      @(negedge clk);
      chk("hold_rise", 64'(txenB), 64'd1);
      n = 0;
      while (txenB && n < 100) begin
        n++;
        @(negedge clk);
      end
      chk("hold_enlen", 64'(n), 64'd24);
      g = 1;
      while (!doneB && g < 100) begin
        @(negedge clk);
        g++;
      end
      chk("hold_ifg", 64'(g), 64'd24);
      @(negedge clk);
      chk("hold_cnt", 64'(fcB), 64'((f + 1) % 4));
      chk("hold_busy", 64'(busyB), 64'd0);
    end
    stB = 1'b0;
    repeat (60) @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mii_frame_gen.md
Name: mii_frame_gen

Overview:
Parametrised MII (100Base-TX, 4-bit) transmit frame generator for the check unit. It produces complete Ethernet frames on TX_EN/TXD: preamble, SFD, pattern payload, optional zero padding, FCS (CRC-32) and inter-frame gap. Payload length, fill pattern and seed are selected per frame. It drives the PHY transmit side, and its frames are compared against the receive-side CRC checker.

Parameters:
LEN_W, 11, width of frame_len
PAYLOAD_MAX, 1500, upper clamp on payload bytes
MIN_PAYLOAD, 46, payloads shorter than this are zero-padded up to it (0 disables padding)
IFG_BYTES, 12, inter-frame gap in byte times (2 clocks per byte)
CNT_W, 16, width of frame_cnt

Ports:
clk_25Mz  in  1  MII transmit clock; all logic on its rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  frame request; sampled only in IDLE
frame_len  in  LEN_W  payload byte count; latched on accepted start
pattern_sel  in  2  0 incrementing, 1 constant, 2 PRBS-8, 3 alternating 0x55/0xAA; latched on start
seed  in  8  pattern start byte; latched on start
TX_EN  out  1  MII transmit enable
TXD  out  4  MII transmit nibble
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at end of IFG
frame_cnt  out  CNT_W  completed frames, wraps to 0
crc_out  out  32  FCS of last completed frame

Behaviour:
- Reset (async, reset_n=0): TX_EN=0, TXD=0, busy=0, done=0, frame_cnt=0, crc_out=0, FSM=IDLE. Mid-frame reset drops TX_EN at once, with no truncation marker.
- FSM states: IDLE -> PRE -> PAY -> PAD -> FCS -> IFG -> IDLE.
- IDLE: when start=1, latch the parameters, set busy=1, go to PRE. start is ignored in every other state. start held high re-triggers only on the cycle after done.
- Effective length L = min(frame_len, PAYLOAD_MAX). Padding bytes P = max(MIN_PAYLOAD - L, 0).
- PRE: TX_EN=1 starting on the cycle after the start sample. TXD=0x5 for 15 cycles, then 0xD for 1 cycle (7 x 0x55 + 0xD5).
- Nibble order: every byte is sent low nibble first, then high nibble.
- PAY: sends L bytes. The pattern restarts each frame.
  - Mode 0: seed, seed+1, ... (mod 256).
  - Mode 1: seed repeated.
  - Mode 2: Galois LFSR. First byte is b0 = seed, with 0x00 replaced by 0x01. Next b = (b<<1)^(b[7]?0x1D:0x00), 8-bit.
  - Mode 3: 0x55, 0xAA, ... (seed ignored).
- PAD: P bytes of 0x00. PAD is skipped if P=0, and PAY is skipped if L=0.
- CRC-32 (IEEE 802.3, reflected poly 0xEDB88320): init 0xFFFFFFFF, computed over payload and pad bytes, result XOR 0xFFFFFFFF.
- FCS: 4 bytes, LSB byte first, low nibble first (8 cycles).
- TX_EN high duration is exactly 16 + 2(L+P) + 8 cycles, with no gaps.
- IFG: TX_EN=0, TXD=0 for 2*IFG_BYTES cycles. On the last IFG cycle: done=1, frame_cnt increments (wraps), crc_out updates to the FCS. busy drops on the next cycle with the FSM in IDLE.
- TXD=0 whenever TX_EN=0.

Test Plan:
- Reset mid-PAY: assert reset_n=0 at payload byte 10 -> TX_EN=0 the same cycle, busy=0, frame_cnt=0. A new start after release gives a full frame.
- MIN_PAYLOAD=0, frame_len=9, pattern_sel=0, seed=0x31 (payload "123456789") -> FCS nibbles 6,2,9,3,4,F,B,C, crc_out=0xCBF43926, TX_EN high 42 cycles, done 24 cycles after TX_EN falls.
- Defaults, frame_len=10 -> 10 pattern bytes then 36 zero bytes, TX_EN high 16+92+8=116 cycles. frame_len=2000 -> clamped to 1500 bytes (3024 cycles).
- pattern_sel=2, seed=0x01, MIN_PAYLOAD=0, frame_len=10 -> bytes 01,02,04,08,10,20,40,80,1D,3A. seed=0x00 gives the identical sequence.
- MIN_PAYLOAD=0, frame_len=0 -> preamble/SFD then FCS 0x00000000 (8 zero nibbles), TX_EN high 24 cycles.
- start held high for 3 frames with CNT_W=2 -> start pulses during busy are ignored, IFG is exactly 24 cycles between frames, frame_cnt goes 1,2,3, then 0 after a 4th frame.
